// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory
// and holds the core until a complete, checksum-clean image has landed.
module imem_boot_loader #(
    parameter int MEM_BYTES = 8192,
    parameter int ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] MAX_LEN = 17'(MEM_BYTES);

    state_t            state, state_nx;
    logic [15:0]       len;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        csum;
    logic              xfer, wr, last, len_bad;
    logic [15:0]       len_full;

    assign busy     = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
    assign rx_ready = busy;
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign cpu_hold = (state != DONE);

    assign xfer     = rx_valid && rx_ready;
    assign wr       = (state == DATA) && xfer;
    assign len_full = {rx_data, len[7:0]};
    assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);
    assign last     = 17'(cnt) == ({1'b0, len} - 17'd1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = LEN_LO;
            LEN_LO: if (abort) state_nx = ERR;
                    else if (xfer) state_nx = LEN_HI;
            LEN_HI: if (abort) state_nx = ERR;
                    else if (xfer) state_nx = len_bad ? ERR : DATA;
            DATA:   if (abort) state_nx = ERR;
                    else if (xfer && last) state_nx = CSUM;
            CSUM:   if (abort) state_nx = ERR;
                    else if (xfer) state_nx = (rx_data == csum) ? DONE : ERR;
            DONE, ERR: if (start) state_nx = LEN_LO;
            default: state_nx = IDLE;
        endcase
    end

    // The write for a byte accepted on an abort edge still goes out; only later bytes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= '0;
            cnt       <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            mem_we    <= wr;
            mem_waddr <= wr ? cnt : '0;
            mem_wdata <= wr ? rx_data : '0;
            if (state_nx == LEN_LO && state != LEN_LO) begin
                len  <= '0;
                cnt  <= '0;
                csum <= '0;
            end else if (xfer) begin
                case (state)
                    LEN_LO: len[7:0]  <= rx_data;
                    LEN_HI: len[15:8] <= rx_data;
                    DATA: begin
                        cnt  <= cnt + ADDR_W'(1);
                        csum <= csum ^ rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed + randomized bench for imem_boot_loader against a frame-level model.
module tb_imem_boot_loader;
    localparam int MEM_BYTES = 8192;
    localparam int ADDR_W    = 13;
    typedef logic [7:0] bq_t[$];

    logic              clk = 0, rst_n = 0, start = 0, abort = 0, rx_valid = 0;
    logic [7:0]        rx_data = 0;
    logic              rx_ready, mem_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    int tests = 0, fails = 0, cyc = 0;
    int x_cyc[$];
    int w_cyc[$], w_addr[$], w_data[$];

    imem_boot_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // A transfer seen at this negedge completes on the next posedge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid && rx_ready) x_cyc.push_back(cyc);
        if (mem_we) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(int'(mem_waddr));
            w_data.push_back(int'(mem_wdata));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        x_cyc.delete(); w_cyc.delete(); w_addr.delete(); w_data.delete();
    endtask

    task automatic step(); @(posedge clk); #1; endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        rx_valid = 0;
        repeat (gap) step();
        rx_valid = 1; rx_data = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (rx_ready) ok = 1;
            step();
        end
        rx_valid = 0;
        if (!ok) begin
            tests++; fails++;
            $error("FAIL send_timeout: got no rx_ready want rx_ready");
        end
    endtask

    task automatic run_frame(input bq_t q, input bit rnd);
        clear_log();
        pulse_start();
        foreach (q[i]) send_byte(q[i], rnd ? int'($urandom_range(0, 2)) : 0);
        repeat (3) step();
    endtask

    // Model: derive expected writes and outcome from the frame itself.
    task automatic check_frame(input string tag, input bq_t q);
        int len = int'(q[0]) | (int'(q[1]) << 8);
        bit len_ok = (len != 0) && (len <= MEM_BYTES);
        int nw = len_ok ? len : 0;
        logic [7:0] x = 0;
        bit good;
        for (int i = 0; i < nw; i++) x ^= q[2 + i];
        good = len_ok && (x == q[2 + len]);
        chk({tag, "_nwrites"}, w_cyc.size(), nw);
        for (int i = 0; i < nw && i < w_cyc.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), w_addr[i], i);
            chk($sformatf("%s_data%0d", tag, i), w_data[i], int'(q[2 + i]));
            chk($sformatf("%s_lat%0d", tag, i), w_cyc[i], x_cyc[2 + i] + 1);
        end
        chk({tag, "_done"}, done, good);
        chk({tag, "_err"}, err, !good);
        chk({tag, "_hold"}, cpu_hold, !good);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"}, rx_ready, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_waddr"}, mem_waddr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_hold"}, cpu_hold, 1);
    endtask

    initial begin
        bq_t q;
        int nw;
        #12;
        chk_reset_outs("rst");
        rst_n = 1;
        step(); step();
        chk("post_rst_idle", busy, 0);

        q = '{8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_frame(q, 0);
        check_frame("good", q);

        q = '{8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        run_frame(q, 0);
        check_frame("badsum", q);

        q = '{8'h00, 8'h00};
        run_frame(q, 0);
        check_frame("len0", q);

        q = '{8'h01, 8'h20};
        run_frame(q, 0);
        check_frame("len8193", q);

        // Random payload, random valid gaps, checksum usually right.
        for (int r = 0; r < 3; r++) begin
            logic [7:0] x = 0;
            q = '{8'h08, 8'h00};
            for (int i = 0; i < 8; i++) begin
                q.push_back(8'($urandom));
                x ^= q[2 + i];
            end
            q.push_back((r == 2) ? ~x : x);
            run_frame(q, 1);
            check_frame($sformatf("rnd%0d", r), q);
        end

        // Abort right after the second payload byte.
        clear_log();
        pulse_start();
        send_byte(8'h08, 0); send_byte(8'h00, 0);
        send_byte(8'hA5, 0); send_byte(8'h5A, 0);
        abort = 1; step(); abort = 0;
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 0);
        repeat (3) step();
        chk("abort_nwrites", w_cyc.size(), 2);
        if (w_cyc.size() == 2) begin
            chk("abort_a1", w_addr[1], 1);
            chk("abort_d1", w_data[1], 8'h5A);
        end
        q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        run_frame(q, 0);
        check_frame("after_abort", q);

        // Reset mid-DATA while a write strobe is up.
        clear_log();
        pulse_start();
        send_byte(8'h04, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        chk("mid_we_up", mem_we, 1);
        rx_valid = 1; rx_data = 8'hCC;
        #1 rst_n = 0;
        #1 chk_reset_outs("midrst");
        nw = w_cyc.size();
        repeat (2) step();
        rx_valid = 0;
        rst_n = 1;
        repeat (4) step();
        chk("midrst_nowrites", w_cyc.size(), nw);
        chk("midrst_idle", busy, 0);
        chk("midrst_hold", cpu_hold, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 8192: instruction-memory capacity in bytes.
REQ-002 SHALL have parameter ADDR_W, default 13: byte-address width, with 2**ADDR_W == MEM_BYTES.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port abort  input  1  cancels the load in progress.
REQ-007 SHALL have port rx_data  input  8  byte-stream data.
REQ-008 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-009 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we  output  1  byte write strobe to the instruction memory.
REQ-011 SHALL have port mem_waddr  output  ADDR_W  byte write address.
REQ-012 SHALL have port mem_wdata  output  8  byte write data.
REQ-013 SHALL have port cpu_hold  output  1  holds the core, with no fetch, while the memory is invalid.
REQ-014 SHALL have port busy  output  1  a load is in progress.
REQ-015 SHALL have port done  output  1  the last load succeeded.
REQ-016 SHALL have port err  output  1  the last load failed.

Function
REQ-017 SHALL implement the states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE and ERR.
REQ-018 SHALL define a byte transfer as rx_valid && rx_ready on a rising clk edge.
REQ-019 SHALL drive rx_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM.
REQ-020 SHALL never let rx_ready depend combinationally on rx_valid.
REQ-021 SHALL use the stream frame: len[7:0], len[15:8], len payload bytes, then 1 checksum byte.
REQ-022 SHALL compute the checksum as the XOR of all payload bytes.
REQ-023 SHALL transition IDLE->LEN_LO on start=1.
REQ-024 SHALL transition LEN_LO->LEN_HI on a transfer, latching the low length byte.
REQ-025 SHALL, on the LEN_HI transfer, go to ERR if len==0 or len>MEM_BYTES, else to DATA.
REQ-026 SHALL, in DATA, for each transfer k (0-based), pulse mem_we=1 for exactly one cycle, in the cycle after the transfer.
REQ-027 SHALL drive mem_waddr=k and mem_wdata equal to that byte during that mem_we pulse.
REQ-028 SHALL go DATA->CSUM on transfer k==len-1.
REQ-029 SHALL allow back-to-back transfers, one byte per cycle, with no bubbles required.
REQ-030 SHALL compare the CSUM transfer byte to the running XOR: equal -> DONE, else -> ERR.
REQ-031 SHALL drive mem_we=0, mem_waddr=0 and mem_wdata=0 outside write pulses.
REQ-032 SHALL write no memory address beyond len-1.
REQ-033 SHALL drive busy=1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 otherwise.
REQ-034 SHALL drive done=1 only in DONE.
REQ-035 SHALL drive err=1 only in ERR.
REQ-036 SHALL drive cpu_hold=0 only in DONE, and 1 in every other state.
REQ-037 SHALL ignore start while busy=1.
REQ-038 SHALL, on start in DONE or ERR, go to LEN_LO and clear done/err on that edge.
REQ-039 SHALL, on abort while busy=1, go to ERR on the next edge and issue no further mem_we; the write for a final byte accepted on the same edge SHALL still be issued.
REQ-040 SHALL ignore abort in IDLE, DONE and ERR.
REQ-041 SHALL give abort priority over start and over a simultaneous byte transfer's state transition.
REQ-042 SHALL clear the byte counter and running XOR on every entry to LEN_LO.

Reset
REQ-043 SHALL, on rst_n=0, immediately and asynchronously set state=IDLE, rx_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=1, length=0, counter=0, XOR=0.
REQ-044 SHALL apply reset mid-load identically, with no pending write issued.
REQ-045 SHALL leave state unchanged on the first clk edge after rst_n deasserts unless start=1.

Verification
REQ-046 Bench SHALL check: start, stream 04 00 13 00 00 00 13 -> writes (0,13),(1,00),(2,00),(3,00), each one cycle after its transfer; DONE; done=1; cpu_hold=0.
REQ-047 Bench SHALL check: same frame with checksum 12 -> all 4 writes occur, then err=1, cpu_hold=1, done=0.
REQ-048 Bench SHALL check: length 00 00, and separately 01 20 (8193) -> ERR after the 2nd byte with zero mem_we pulses.
REQ-049 Bench SHALL check: rx_valid toggling randomly with len=8 -> exactly 8 writes to addresses 0..7 in order, then DONE.
REQ-050 Bench SHALL check: abort after the 2nd payload byte -> ERR next edge, exactly 2 writes; then start + valid frame -> DONE.
REQ-051 Bench SHALL check: rst_n=0 mid-DATA -> all outputs at reset values without a clk edge; cpu_hold=1; no later writes.
